// File: rtl/rf_read_arbiter.sv
// Round-robin read arbiter for two requesters sharing one 32:1 register-read MUX.
// Each read walks IDLE -> READ -> RESP; all outputs come straight from flops.
module rf_read_arbiter #(
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic [4:0]  Addr0,
  input  logic        Req1,
  input  logic [4:0]  Addr1,
  input  logic [31:0] MuxF,
  output logic [4:0]  Sel,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Valid0,
  output logic        Valid1,
  output logic [31:0] Data,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        last_r, last_nxt_s;
  logic        win_r, win_nxt_s, win_s, any_req_s;
  logic [4:0]  sel_r, sel_nxt_s;
  logic [31:0] data_r, data_nxt_s;
  logic        gnt0_r, gnt1_r, gnt0_nxt_s, gnt1_nxt_s;
  logic        valid0_r, valid1_r, valid0_nxt_s, valid1_nxt_s;
  logic        busy_r, busy_nxt_s;

  // Register 0 reads as zero when hardwired, otherwise passes the MUX value.
  function automatic logic [31:0] gate_zero(input logic [4:0] sel, input logic [31:0] muxf);
    logic [31:0] res;
    if (ZERO_REG_HARDWIRED && (sel == 5'd0)) begin
      res = 32'h0000_0000;
    end else begin
      res = muxf;
    end
    return res;
  endfunction

  // Arbitration: a lone request wins; on a tie the requester that did not win last time goes.
  always_comb begin
    any_req_s = Req0 | Req1;
    if (Req0 && Req1) begin
      win_s = ~last_r;
    end else if (Req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ:    state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the output flops; Req/Addr only reach Sel through a flop.
  always_comb begin
    sel_nxt_s    = sel_r;
    data_nxt_s   = data_r;
    last_nxt_s   = last_r;
    win_nxt_s    = win_r;
    gnt0_nxt_s   = 1'b0;
    gnt1_nxt_s   = 1'b0;
    valid0_nxt_s = 1'b0;
    valid1_nxt_s = 1'b0;
    busy_nxt_s   = (state_nxt_s != IDLE);
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          sel_nxt_s  = win_s ? Addr1 : Addr0;
          win_nxt_s  = win_s;
          last_nxt_s = win_s;
          gnt0_nxt_s = ~win_s;
          gnt1_nxt_s = win_s;
        end else begin
          sel_nxt_s  = sel_r;
        end
      end
      READ: begin
        data_nxt_s   = gate_zero(sel_r, MuxF);
        valid0_nxt_s = ~win_r;
        valid1_nxt_s = win_r;
      end
      RESP: begin
        data_nxt_s = data_r;
      end
      default: begin
        data_nxt_s = data_r;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output and arbitration-history registers; Last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sel_r    <= 5'd0;
      data_r   <= 32'h0000_0000;
      last_r   <= 1'b1;
      win_r    <= 1'b0;
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      sel_r    <= sel_nxt_s;
      data_r   <= data_nxt_s;
      last_r   <= last_nxt_s;
      win_r    <= win_nxt_s;
      gnt0_r   <= gnt0_nxt_s;
      gnt1_r   <= gnt1_nxt_s;
      valid0_r <= valid0_nxt_s;
      valid1_r <= valid1_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  assign Sel    = sel_r;
  assign Data   = data_r;
  assign Gnt0   = gnt0_r;
  assign Gnt1   = gnt1_r;
  assign Valid0 = valid0_r;
  assign Valid1 = valid1_r;
  assign Busy   = busy_r;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed self-checking bench for rf_read_arbiter; a second instance with the
// zero register not hardwired shares the stimulus.
module tb_rf_read_arbiter;

  logic        Clk;
  logic        Rst;
  logic        Req0, Req1;
  logic [4:0]  Addr0, Addr1;
  logic [31:0] MuxF;
  logic [4:0]  Sel, Sel_nz;
  logic        Gnt0, Gnt1, Valid0, Valid1, Busy;
  logic        Gnt0_nz, Gnt1_nz, Valid0_nz, Valid1_nz, Busy_nz;
  logic [31:0] Data, Data_nz;
  logic        force_dead;

  int n_cmp;
  int n_err;

  rf_read_arbiter #(.ZERO_REG_HARDWIRED(1'b1)) u_dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Addr0(Addr0), .Req1(Req1), .Addr1(Addr1),
    .MuxF(MuxF), .Sel(Sel), .Gnt0(Gnt0), .Gnt1(Gnt1), .Valid0(Valid0), .Valid1(Valid1),
    .Data(Data), .Busy(Busy)
  );

  rf_read_arbiter #(.ZERO_REG_HARDWIRED(1'b0)) u_dut_nz (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Addr0(Addr0), .Req1(Req1), .Addr1(Addr1),
    .MuxF(MuxF), .Sel(Sel_nz), .Gnt0(Gnt0_nz), .Gnt1(Gnt1_nz), .Valid0(Valid0_nz),
    .Valid1(Valid1_nz), .Data(Data_nz), .Busy(Busy_nz)
  );

  // Register file model: entry k holds k, or every entry reads DEADBEEF when forced.
  assign MuxF = force_dead ? 32'hDEAD_BEEF : {27'd0, Sel};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0;
    #2;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  // One complete read: grant cycle, valid cycle, then back in IDLE.
  task automatic do_read(input string tag, input logic win, input logic [4:0] addr,
                         input logic [31:0] data);
    step();
    chk({tag, " gnt"},  {30'd0, Gnt1, Gnt0}, win ? 32'd2 : 32'd1);
    chk({tag, " sel"},  {27'd0, Sel}, {27'd0, addr});
    chk({tag, " busy1"}, {31'd0, Busy}, 32'd1);
    chk({tag, " vld_in_gnt"}, {30'd0, Valid1, Valid0}, 32'd0);
    step();
    chk({tag, " vld"},  {30'd0, Valid1, Valid0}, win ? 32'd2 : 32'd1);
    chk({tag, " data"}, Data, data);
    chk({tag, " gnt_in_vld"}, {30'd0, Gnt1, Gnt0}, 32'd0);
    step();
    chk({tag, " idle_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, " idle_vld"}, {30'd0, Valid1, Valid0}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Rst = 1'b0;
    Req0 = 1'b0;
    Req1 = 1'b0;
    Addr0 = 5'd0;
    Addr1 = 5'd0;
    force_dead = 1'b0;
    #23;
    chk("rst sel",  {27'd0, Sel}, 32'd0);
    chk("rst data", Data, 32'd0);
    chk("rst ctl",  {27'd0, Busy, Gnt1, Gnt0, Valid1, Valid0}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Single read of register 5, then Data must ignore later MUX changes.
    Req0 = 1'b1;
    Addr0 = 5'd5;
    step();
    chk("single gnt", {30'd0, Gnt1, Gnt0}, 32'd1);
    chk("single sel", {27'd0, Sel}, 32'd5);
    step();
    chk("single vld", {30'd0, Valid1, Valid0}, 32'd1);
    chk("single data", Data, 32'd5);
    Req0 = 1'b0;
    force_dead = 1'b1;
    step();
    chk("single hold", Data, 32'd5);
    chk("single idle", {31'd0, Busy}, 32'd0);
    step();
    chk("single hold2", Data, 32'd5);
    force_dead = 1'b0;

    // Tie after reset alternates starting with requester 0.
    do_reset();
    Req0 = 1'b1;
    Req1 = 1'b1;
    Addr0 = 5'd3;
    Addr1 = 5'd12;
    do_read("tie0", 1'b0, 5'd3, 32'd3);
    do_read("tie1", 1'b1, 5'd12, 32'd12);
    do_read("tie2", 1'b0, 5'd3, 32'd3);
    Req0 = 1'b0;
    Req1 = 1'b0;

    // Zero register with the MUX forced to DEADBEEF.
    force_dead = 1'b1;
    Req1 = 1'b1;
    Addr1 = 5'd0;
    do_read("zero", 1'b1, 5'd0, 32'd0);
    chk("zero nz data", Data_nz, 32'hDEAD_BEEF);
    Req1 = 1'b0;
    force_dead = 1'b0;

    // Changes during READ are ignored; the late request is served next.
    Req0 = 1'b1;
    Addr0 = 5'd7;
    step();
    chk("ign gnt", {30'd0, Gnt1, Gnt0}, 32'd1);
    chk("ign sel", {27'd0, Sel}, 32'd7);
    Req1 = 1'b1;
    Addr1 = 5'd9;
    Addr0 = 5'd20;
    step();
    chk("ign vld", {30'd0, Valid1, Valid0}, 32'd1);
    chk("ign data", Data, 32'd7);
    chk("ign sel hold", {27'd0, Sel}, 32'd7);
    Req0 = 1'b0;
    step();
    chk("ign idle", {31'd0, Busy}, 32'd0);
    do_read("ign req1", 1'b1, 5'd9, 32'd9);
    Req1 = 1'b0;

    // Reset asserted mid-read aborts it without a Valid pulse.
    Req0 = 1'b1;
    Addr0 = 5'd6;
    step();
    chk("abort gnt", {30'd0, Gnt1, Gnt0}, 32'd1);
    #2;
    Rst = 1'b0;
    #1;
    chk("abort sel",  {27'd0, Sel}, 32'd0);
    chk("abort data", Data, 32'd0);
    chk("abort ctl",  {27'd0, Busy, Gnt1, Gnt0, Valid1, Valid0}, 32'd0);
    step();
    chk("abort novld", {27'd0, Busy, Gnt1, Gnt0, Valid1, Valid0}, 32'd0);
    Req1 = 1'b1;
    Addr0 = 5'd3;
    Addr1 = 5'd12;
    @(negedge Clk);
    Rst = 1'b1;
    do_read("post rst", 1'b0, 5'd3, 32'd3);
    Req0 = 1'b0;
    Req1 = 1'b0;

    // Address sweep over the whole register file.
    for (int a = 0; a < 32; a++) begin
      Req0 = 1'b1;
      Addr0 = 5'(a);
      do_read($sformatf("sweep%0d", a), 1'b0, 5'(a), 32'(a));
    end
    Req0 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
